booth_r4_seq_mult: RTL

- Sequential signed radix-4 Booth multiplier for the FFT datapath; it computes one W x W twiddle/sample product in W/2 iterations.
- It sits directly upstream of the butterfly adders. Each iteration, the block selects a Booth window and adds the weighted partial product into a 2W-bit accumulator.
- It uses a valid/ready handshake on both sides, so the FFT sequencer can stall it.

---
 rtl/fft_mult_pkg.sv | 40 ++++
 rtl/booth_r4_pp_sel.sv | 31 +++
 rtl/booth_r4_seq_mult.sv | 116 +++++++++++
 3 files changed

// File: rtl/fft_mult_pkg.sv
// ============================================================================
// fft_mult_pkg : state and Booth window encodings shared by the FFT multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package fft_mult_pkg;

    localparam int FFT_MULT_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BW_ZERO = 3'd0,
        BW_P1   = 3'd1,
        BW_P2   = 3'd2,
        BW_M1   = 3'd3,
        BW_M2   = 3'd4
    } booth_e;

    // Radix-4 recoding of {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_e booth_decode(input logic [2:0] win);
        booth_e code;
        case (win)
            3'b001, 3'b010: code = BW_P1;
            3'b011:         code = BW_P2;
            3'b100:         code = BW_M2;
            3'b101, 3'b110: code = BW_M1;
            default:        code = BW_ZERO;
        endcase
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/booth_r4_pp_sel.sv
// ============================================================================
// booth_r4_pp_sel : combinational radix-4 Booth partial-product selector
// Revision 1.0
// ============================================================================
`default_nettype none

import fft_mult_pkg::*;

module booth_r4_pp_sel #(
    parameter int W = FFT_MULT_W
) (
    input  logic        [2:0]   window_i,
    input  logic signed [W+1:0] m_ext_i,
    output logic signed [W+1:0] pp_o
);

    // W+2 bits keep -2M exact even for the most negative multiplicand
    always_comb begin
        pp_o = '0;
        case (booth_decode(window_i))
            BW_P1:   pp_o = m_ext_i;
            BW_P2:   pp_o = m_ext_i <<< 1;
            BW_M1:   pp_o = -m_ext_i;
            BW_M2:   pp_o = -(m_ext_i <<< 1);
            default: pp_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/booth_r4_seq_mult.sv
// ============================================================================
// booth_r4_seq_mult : sequential signed radix-4 Booth multiplier, W/2 cycles
// Revision 1.0
// ============================================================================
`default_nettype none

import fft_mult_pkg::*;

module booth_r4_seq_mult #(
    parameter int W = FFT_MULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           abort,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int            ITERS     = W / 2;
    localparam int            IW        = $clog2(ITERS);
    localparam logic [IW-1:0] LAST_ITER = IW'(ITERS - 1);

    state_e           state_q, state_d;
    logic [W-1:0]     m_q,     m_d;
    logic [W:0]       b_q,     b_d;
    logic [2*W-1:0]   acc_q,   acc_d;
    logic [IW-1:0]    iter_q,  iter_d;

    logic        [2:0]     w_window;
    logic signed [W+1:0]   w_m_ext;
    logic signed [W+1:0]   w_pp;
    logic        [2*W-1:0] w_pp_ext;
    logic        [2*W-1:0] w_addend;

    // b_q carries an implicit zero below the LSB so window 0 reads b[-1]=0
    assign w_window = b_q[{iter_q, 1'b0} +: 3];
    assign w_m_ext  = {{2{m_q[W-1]}}, m_q};
    assign w_pp_ext = {{(W-2){w_pp[W+1]}}, w_pp};
    assign w_addend = w_pp_ext << {iter_q, 1'b0};

    booth_r4_pp_sel #(
        .W (W)
    ) u_pp_sel (
        .window_i (w_window),
        .m_ext_i  (w_m_ext),
        .pp_o     (w_pp)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        b_d     = b_q;
        acc_d   = acc_q;
        iter_d  = iter_q;
        if (abort) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            iter_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        m_d     = mcand;
                        b_d     = {mplier, 1'b0};
                        acc_d   = '0;
                        iter_d  = '0;
                        state_d = ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_d  = acc_q + w_addend;
                    iter_d = iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            iter_q  <= iter_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC);
    assign out_valid = (state_q == ST_DONE);
    assign product   = acc_q;

endmodule

`default_nettype wire
